// File: rtl/matrix_dsp_pkg.sv
// Shared definitions for the matrix DSP sequencer: FSM state encoding,
// the end-of-program opcode and the post-issue blanking length.
package matrix_dsp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CHECK = 3'd2,
    ST_ISSUE = 3'd3,
    ST_BLANK = 3'd4,
    ST_WAIT  = 3'd5
  } seqState_t;

  localparam logic [2:0]  OP_END       = 3'd7;
  localparam int unsigned BLANK_CYCLES = 2;
  localparam int unsigned STEP_BITS    = 9;

endpackage

// File: rtl/matrix_dsp_sequencer.sv
// Lockstep microcode sequencer driving NUM_UNITS matrix DSP axis units.
// Optional step-count watchdog: define MATRIX_DSP_SEQ_TIMEOUT_EN.
module matrix_dsp_sequencer
  import matrix_dsp_pkg::*;
#(
  parameter int unsigned NUM_UNITS     = 4,
  parameter int unsigned TIMEOUT_STEPS = 512
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [7:0]           startPc,
  input  logic                 abort,
  output logic [7:0]           programCounter,
  output logic                 instructionGrab,
  output logic                 submit,
  input  logic [NUM_UNITS-1:0] unitReady,
  input  logic [NUM_UNITS-1:0] unitProgramReady,
  output logic                 busy,
  output logic                 done,
  output logic [STEP_BITS-1:0] stepCount
`ifdef MATRIX_DSP_SEQ_TIMEOUT_EN
  ,
  output logic                 timeoutError
`endif
);

  localparam int unsigned BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

`ifndef MATRIX_DSP_SEQ_TIMEOUT_EN
  // Parameter stays on the interface so both builds share one instantiation.
  localparam int unsigned unusedTimeoutSteps = TIMEOUT_STEPS;
`endif

  seqState_t     state;
  logic [BW-1:0] blankCnt;
  logic          allReady;
  logic          allEnd;

  assign allReady = &unitReady;
  assign allEnd   = &unitProgramReady;

  assign instructionGrab = (state == ST_FETCH);
  assign submit          = (state == ST_ISSUE);
  assign busy            = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      programCounter <= '0;
      stepCount      <= '0;
      blankCnt       <= '0;
      done           <= 1'b0;
`ifdef MATRIX_DSP_SEQ_TIMEOUT_EN
      timeoutError   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MATRIX_DSP_SEQ_TIMEOUT_EN
      timeoutError <= 1'b0;
`endif
      // Abort outranks every other transition, but IDLE still honours start.
      if (abort && (state != ST_IDLE)) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              programCounter <= startPc;
              stepCount      <= '0;
              state          <= ST_FETCH;
            end
          end
          ST_FETCH: state <= ST_CHECK;
          ST_CHECK: begin
            if (allEnd) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else if (allReady) begin
              state <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (stepCount != '1) stepCount <= stepCount + 1'b1;
            blankCnt <= '0;
`ifdef MATRIX_DSP_SEQ_TIMEOUT_EN
            if (({23'd0, stepCount} + 32'd1) >= TIMEOUT_STEPS) begin
              timeoutError <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              state <= ST_BLANK;
            end
`else
            state <= ST_BLANK;
`endif
          end
          // Units still show the previous ready while their DSP start propagates.
          ST_BLANK: begin
            if (blankCnt == BLANK_LAST) state <= ST_WAIT;
            else                        blankCnt <= blankCnt + 1'b1;
          end
          ST_WAIT: begin
            if (allReady) begin
              programCounter <= programCounter + 8'd1;
              state          <= ST_FETCH;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
